// File: rtl/parking_occupancy_ctrl.sv
// parking_occupancy_ctrl: saturating lot occupancy counter with entry-barrier open/timeout/guard sequencing
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   car_in, car_out     one-cycle pulses from the lane sensor FSM (entry / exit completed)
//   entry_req           level request for the entry barrier
//   gate_open           registered barrier-up command
//   count, full, empty  registered occupancy and its decodes
//   reject, timeout     one-cycle pulses: refused (lot full) / barrier closed with no car
//   err                 sticky over/underflow or tailgate flag, cleared only by reset
module parking_occupancy_ctrl #(
    parameter int CAPACITY     = 16,
    parameter int CNT_W        = 5,
    parameter int GATE_TIMEOUT = 100,
    parameter int GUARD_CYCLES = 4,
    parameter int TIMER_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             car_in,
    input  logic             car_out,
    input  logic             entry_req,
    output logic             gate_open,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             reject,
    output logic             timeout,
    output logic             err
);
    typedef enum logic [1:0] {IDLE, OPEN, GUARD} state_t;
    localparam logic [CNT_W-1:0]   CAP    = CNT_W'(CAPACITY);
    localparam logic [TIMER_W-1:0] T_LAST = TIMER_W'(GATE_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] G_LAST = TIMER_W'(GUARD_CYCLES - 1);
    state_t state, state_n;
    logic [TIMER_W-1:0] timer, timer_n;
    logic [CNT_W-1:0] count_n;
    logic reject_n, timeout_n, err_n, inc, dec;
    assign full  = count == CAP;
    assign empty = count == '0;
    assign inc   = car_in & !car_out;
    assign dec   = car_out & !car_in;
    always_comb begin
        state_n   = state;
        reject_n  = 1'b0;
        timeout_n = 1'b0;
        if (state == IDLE) begin
            state_n  = (entry_req & !full) ? OPEN : IDLE;
            reject_n = entry_req & full;
        end else if (state == OPEN) begin
            // a car in the final open cycle wins over the timeout
            state_n   = (car_in || timer == T_LAST) ? GUARD : OPEN;
            timeout_n = !car_in && timer == T_LAST;
        end else begin
            state_n = (timer == G_LAST) ? IDLE : GUARD;
        end
        timer_n = (state_n != state || state == IDLE) ? '0 : timer + 1'b1;
        count_n = (inc & !full) ? count + 1'b1 : (dec & !empty) ? count - 1'b1 : count;
        // tailgate: any car_in outside OPEN is counted but flagged
        err_n   = err | (inc & full) | (dec & empty) | (car_in & state != OPEN);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            timer     <= '0;
            count     <= '0;
            gate_open <= 1'b0;
            reject    <= 1'b0;
            timeout   <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            timer     <= timer_n;
            count     <= count_n;
            gate_open <= state_n == OPEN;
            reject    <= reject_n;
            timeout   <= timeout_n;
            err       <= err_n;
        end
    end
endmodule
